// File: rtl/regfile_cc_if.sv
// Operand/write-back bundle between the LC-3b control datapath and the register file / CC unit.
interface regfile_cc_if #(
  parameter int WIDTH = 16
);
  logic [15:0]      ir;
  logic [WIDTH-1:0] bus;
  logic             ld_reg;
  logic             ld_cc;
  logic             ld_ben;
  logic             dr_mux;
  logic             sr1_mux;
  logic [WIDTH-1:0] sr1_out;
  logic [WIDTH-1:0] sr2_out;
  logic             n;
  logic             z;
  logic             p;
  logic             ben;

  modport master (
    output ir, bus, ld_reg, ld_cc, ld_ben, dr_mux, sr1_mux,
    input  sr1_out, sr2_out, n, z, p, ben
  );

  modport slave (
    input  ir, bus, ld_reg, ld_cc, ld_ben, dr_mux, sr1_mux,
    output sr1_out, sr2_out, n, z, p, ben
  );
endinterface

// File: rtl/regfile_cc.sv
// LC-3b general register file with N/Z/P condition codes and branch-enable latch.
// Reads are combinational with no write-through; all loads are independent strobes.
module regfile_cc #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_cc_if.slave  rf
);
  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0] regs_reg [NREGS];
  logic             n_reg, z_reg, p_reg, ben_reg;
  logic             n_next, z_next, p_next, ben_next;
  logic [AW-1:0]    dr, sr1, sr2;

  // IR register fields are 3 bits wide, which is why NREGS must stay 8
  always_comb begin
    dr  = rf.dr_mux  ? AW'(NREGS - 1) : rf.ir[11:9];
    sr1 = rf.sr1_mux ? rf.ir[8:6]     : rf.ir[11:9];
    sr2 = rf.ir[2:0];
  end

  always_comb begin
    n_next   = rf.bus[WIDTH-1];
    z_next   = (rf.bus == '0);
    p_next   = ~rf.bus[WIDTH-1] & (|rf.bus);
    // BEN deliberately uses the flags held before this edge
    ben_next = (rf.ir[11] & n_reg) | (rf.ir[10] & z_reg) | (rf.ir[9] & p_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (rf.ld_reg) begin
      regs_reg[dr] <= rf.bus;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg <= 1'b0;
      z_reg <= 1'b1;
      p_reg <= 1'b0;
    end else if (rf.ld_cc) begin
      n_reg <= n_next;
      z_reg <= z_next;
      p_reg <= p_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ben_reg <= 1'b0;
    end else if (rf.ld_ben) begin
      ben_reg <= ben_next;
    end
  end

  assign rf.sr1_out = regs_reg[sr1];
  assign rf.sr2_out = rf.ir[5] ? {{(WIDTH-5){rf.ir[4]}}, rf.ir[4:0]} : regs_reg[sr2];
  assign rf.n       = n_reg;
  assign rf.z       = z_reg;
  assign rf.p       = p_reg;
  assign rf.ben     = ben_reg;
endmodule
